// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM states, parity modes, baud divisor helper.
// No logic, no latency.
// No flow control; definitions only.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_done on the last count.
// bit_done is combinational from the count; restart zeroes the count next cycle.
// No backpressure; free-running except for restart.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes 8-bit characters as 8N1/8E1/8O1/8N2 frames on txd.
// Latency: pulse (1 cycle) + LOAD (1 cycle) before the start bit; txd is registered.
// Backpressure: one transmit_ready pulse per character, only when idle and enabled.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       connection_status,
    output logic       transmit_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       parity_q, parity_d;
    logic       txd_q, txd_d;
    logic       ready_q, ready_d;
    logic       bit_done;
    logic       restart;

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst),
        .restart  (restart),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;

        unique case (state_q)
            S_IDLE: begin
                if (ready_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d  = word;
                parity_d = (^word) ^ (PARITY == PARITY_ODD);
                state_d  = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // bit_cnt is reused to count stop bits; it is zero on entry.
                if (bit_done) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        restart = (state_d != state_q);

        // Pulse lands in the IDLE cycle; LOAD follows unconditionally.
        ready_d = (state_d == S_IDLE) && connection_status;

        // Line value follows the next state so txd_q lines up with state_q.
        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
        end
    end

    assign transmit_ready = ready_q;
    assign txd            = txd_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 8N1, 8E1, 8O1 and 8N2 instances at 16 clocks per bit.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] word;
    logic [3:0] cs;
    logic [3:0] tr_v, txd_v, busy_v;
    logic [1:0] sel;
    logic       txd_s, busy_s, tr_s;

    int errors = 0;
    int checks = 0;
    int pulses [4];
    int viol = 0;
    logic [3:0] tr_prev = 4'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .word(word), .connection_status(cs[0]),
        .transmit_ready(tr_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));
    uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .word(word), .connection_status(cs[1]),
        .transmit_ready(tr_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));
    uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .word(word), .connection_status(cs[2]),
        .transmit_ready(tr_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));
    uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .word(word), .connection_status(cs[3]),
        .transmit_ready(tr_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

    assign txd_s  = txd_v[sel];
    assign busy_s = busy_v[sel];
    assign tr_s   = tr_v[sel];

    initial begin
        for (int i = 0; i < 4; i++) pulses[i] = 0;
    end

    // Handshake monitor: pulse count per instance, plus pulses that repeat or overlap busy.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (tr_v[i] === 1'b1) begin
                pulses[i] = pulses[i] + 1;
                if (tr_prev[i] === 1'b1 || busy_v[i] === 1'b1) viol = viol + 1;
            end
        end
        tr_prev = tr_v;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for the start bit of the selected instance; presents c only during the LOAD cycle.
    task automatic next_frame(input logic [7:0] c, output int idle_n, output bit ok);
        bit seen;
        idle_n = 0;
        ok     = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (txd_s === 1'b0) begin
                ok = seen;
                break;
            end
            idle_n++;
            if (seen) word = c;
            if (tr_s === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        word = 8'h5A;
    endtask

    // Called at the first START negedge; returns at the negedge after the last bit.
    task automatic capture(input int nbits, input int drop_at, output logic [15:0] bits,
                           output bit stable, output bit busy_all);
        int n;
        bits     = '0;
        stable   = 1'b1;
        busy_all = 1'b1;
        n        = 0;
        for (int b = 0; b < nbits; b++) begin
            bits[b] = txd_s;
            for (int c = 0; c < 16; c++) begin
                if (txd_s !== bits[b]) stable = 1'b0;
                if (busy_s !== 1'b1) busy_all = 1'b0;
                if (n == drop_at) cs[sel] = 1'b0;
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic quiet(input int ncyc, output int bad);
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (txd_s !== 1'b1 || busy_s !== 1'b0) bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          gap, bad, p;
        bit          ok, stable, ball;
        logic [15:0] bits;

        sel  = 2'd0;
        cs   = 4'b0000;
        word = 8'h5A;
        rst  = 1'b1;
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_txd", txd_s, 1);
        check("rst_ready", tr_s, 0);
        check("rst_busy", busy_s, 0);

        rst = 1'b1;
        p = pulses[0];
        quiet(100, bad);
        check("idle_line", bad, 0);
        check("idle_pulses", pulses[0] - p, 0);

        // "Hi\n" streamed with the enable held, dropped during the last frame
        p = pulses[0];
        cs[0] = 1'b1;
        next_frame(8'h48, gap, ok);
        check("h_start", ok, 1);
        capture(10, -1, bits, stable, ball);
        check("h_bits", bits, 16'h0290);
        check("h_stable", stable, 1);
        check("h_busy", ball, 1);
        check("h_end_busy", busy_s, 0);
        check("h_next_pulse", tr_s, 1);

        next_frame(8'h69, gap, ok);
        check("i_start", ok, 1);
        check("i_gap", gap, 2);
        capture(10, -1, bits, stable, ball);
        check("i_bits", bits, 16'h02D2);
        check("i_stable", stable, 1);
        check("i_next_pulse", tr_s, 1);

        next_frame(8'h0A, gap, ok);
        check("nl_start", ok, 1);
        check("nl_gap", gap, 2);
        capture(10, 100, bits, stable, ball);
        check("nl_bits", bits, 16'h0214);
        check("nl_stable", stable, 1);
        check("nl_busy", ball, 1);
        check("nl_end_busy", busy_s, 0);
        check("nl_no_pulse", tr_s, 0);
        check("stream_pulses", pulses[0] - p, 3);

        // Asynchronous reset in the middle of a frame
        cs[0] = 1'b1;
        next_frame(8'h48, gap, ok);
        check("r_start", ok, 1);
        repeat (50) @(negedge clk);
        check("r_pre_txd", txd_s, 0);
        rst = 1'b0;
        #1;
        check("r_arst_txd", txd_s, 1);
        check("r_arst_busy", busy_s, 0);
        check("r_arst_ready", tr_s, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Fresh frame after reset; enable dropped during DATA
        p = pulses[0];
        next_frame(8'h55, gap, ok);
        check("u_start", ok, 1);
        capture(10, 40, bits, stable, ball);
        check("u_bits", bits, 16'h02AA);
        check("u_stable", stable, 1);
        check("u_busy", ball, 1);
        check("u_end_busy", busy_s, 0);
        quiet(60, bad);
        check("u_quiet", bad, 0);
        check("u_pulses", pulses[0] - p, 1);

        // Even parity, odd parity, two stop bits; 0x07 has three ones
        sel = 2'd1;
        cs[1] = 1'b1;
        next_frame(8'h07, gap, ok);
        check("e_start", ok, 1);
        capture(11, 20, bits, stable, ball);
        check("e_bits", bits, 16'h060E);
        check("e_parity", bits[9], 1);
        check("e_stable", stable, 1);
        check("e_busy", ball, 1);
        check("e_end_busy", busy_s, 0);

        sel = 2'd2;
        cs[2] = 1'b1;
        next_frame(8'h07, gap, ok);
        check("o_start", ok, 1);
        capture(11, 20, bits, stable, ball);
        check("o_bits", bits, 16'h040E);
        check("o_parity", bits[9], 0);
        check("o_stable", stable, 1);
        check("o_busy", ball, 1);
        check("o_end_busy", busy_s, 0);

        sel = 2'd3;
        cs[3] = 1'b1;
        next_frame(8'h07, gap, ok);
        check("s2_start", ok, 1);
        capture(11, 20, bits, stable, ball);
        check("s2_bits", bits, 16'h060E);
        check("s2_stable", stable, 1);
        check("s2_busy", ball, 1);
        check("s2_end_busy", busy_s, 0);

        check("handshake", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream UART transmitter stage for the message generator.
- Takes 8-bit characters over a ready/enable handshake and serializes them onto txd as 8N1/8E1/8O1/8N2 frames at a parameterized baud rate.
- Sits between the message/echo source and the board TX pin.
- Asserts a one-cycle request pulse each time it can accept the next character.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 868 at defaults); must be >= 4.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bit count: 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- word  input  8  character to send; sampled as described below.
- connection_status  input  1  transmit enable. 0 means no new frame starts.
- transmit_ready  output  1  one-cycle request pulse: next character wanted.
- txd  output  1  serial line, idle high.
- busy  output  1  high from LOAD through the last stop-bit cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE, txd=1, transmit_ready=0, busy=0, bit counter=0, baud counter=0, shift register=0. Output values are forced immediately, not at the next edge.
- Baud timing: counter runs 0..CLKS_PER_BIT-1 and restarts at every state entry. Each bit occupies exactly CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: txd=1. If connection_status=1, assert transmit_ready for exactly 1 cycle (cycle T), then go to LOAD. If 0, stay in IDLE with no pulse.
  - LOAD (cycle T+1): latch word into shift register; busy=1; compute parity over the latched byte; go to START. The upstream stage registers its new character on the edge ending T, so word is valid during T+1.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, 8 bits, shift right at each bit end. Bit index wraps 7->0, then go to PARITY if PARITY!=0, else STOP.
  - PARITY: even mode sends XOR of bits; odd mode sends its inverse. Lasts one bit time.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE; busy drops on entry to IDLE.
- Frame length: (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles, measured from the START edge to the end of STOP.
- Back-to-back: with connection_status held high, the next transmit_ready pulse is the first IDLE cycle after STOP. The inter-frame gap is 2 extra idle-high cycles (IDLE + LOAD).
- connection_status=0 mid-frame: the current frame completes unchanged; no further pulse is issued.
- connection_status sampled only in IDLE. word sampled only in LOAD. Changes on word at other times are ignored.
- Reset mid-frame: line returns high at once. After release, the block waits in IDLE; no partial frame is resumed.
- transmit_ready is never high in two consecutive cycles and never high while busy=1.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, LOAD, START, DATA, PARITY, STOP);
  - PARITY_NONE/EVEN/ODD constants;
  - function clks_per_bit(CLK_FREQ, BAUD).
- One sub-module, uart_baud_gen: counter with synchronous restart input and a bit_done pulse output on the count of CLKS_PER_BIT-1.
- FSM, shifter and parity stay in the top module.

Test Plan:
- Bench parameters unless stated: CLK_FREQ=1600, BAUD=100 (CLKS_PER_BIT=16).
- Reset held 5 cycles, then released with connection_status=0 for 100 cycles -> txd=1, transmit_ready never pulses, busy=0.
- connection_status=1, word=0x48 presented the cycle after the pulse -> txd bit sequence 0,0,0,0,1,0,0,1,0,1; each bit lasts 16 cycles; frame is 160 cycles; next pulse at the first cycle after STOP.
- Stream "Hi\n" (0x48, 0x69, 0x0A) with connection_status held high -> 3 frames decoded correctly by the bench receiver; exactly 2 idle-high cycles between frames; exactly 3 pulses before connection_status is dropped.
- PARITY=1 with word=0x07, then PARITY=2 with word=0x07 -> parity bit 1 (even) then 0 (odd); frame is 176 cycles. STOP_BITS=2 -> stop high for 32 cycles.
- Assert rst at cycle 50 of a frame -> txd=1 in the same cycle (async), busy=0. After release with connection_status=1, a fresh pulse and a complete new frame follow.
- Drop connection_status during DATA of a 0x55 frame -> frame finishes intact; no transmit_ready pulse afterwards; txd stays 1.
